chip_74163_model: RTL and testbench

- Behavioural emulator of a 74163 4-bit synchronous binary counter. It is the device-side responder to the 74163 checker.
- It receives the checker's pin drives, oversamples them on the system clock, and drives the pins the checker reads back.
- Used on the board-less bench and in FPGA loopback self-test, so every chip checker can be exercised against a good part and against injected faults.

---
 rtl/chip_74163_model.sv | 116 +++++++++++
 tb/tb_chip_74163_model.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_74163_model.sv
// Behavioural 74163 4-bit synchronous counter emulator: oversamples the checker's
// pin drives on Clk, runs the counter on detected chip-CLK rises, returns delayed pins.
module chip_74163_model #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned OUT_DELAY   = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Pin1,
   input  logic       Pin2,
   input  logic       Pin13,
   input  logic       Pin12,
   input  logic       Pin10,
   input  logic       Pin9,
   input  logic       Pin5,
   input  logic       Pin4,
   output logic       Pin11,
   output logic       Pin8,
   output logic       Pin6,
   output logic       Pin3,
   output logic       RCO,
   input  logic [2:0] Fault_Sel,
   output logic [7:0] Edge_Cnt
);

   localparam int unsigned NPINS = 8;
   localparam int unsigned QW    = 4;
   localparam int unsigned CW    = 8;
   localparam int unsigned OW    = QW + 1;

   localparam logic [NPINS-1:0] SYNC_RST = NPINS'(1);

   localparam logic [2:0] F_QA_SA0 = 3'd1;
   localparam logic [2:0] F_QD_SA1 = 3'd2;
   localparam logic [2:0] F_NO_CLR = 3'd3;
   localparam logic [2:0] F_STEP2  = 3'd4;
   localparam logic [2:0] F_NO_EN  = 3'd5;
   localparam logic [2:0] F_LD_REV = 3'd6;
   localparam logic [2:0] F_RCO0   = 3'd7;

   // Pin bundle: [7:4] = D,C,B,A  [3] = EN  [2] = LOAD_n  [1] = CLR_n  [0] = CLK
   logic [NPINS-1:0]                  pins_c;
   logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q;
   logic [NPINS-1:0]                  last_c;
   logic                              clk_prev_q;
   logic [QW-1:0]                     q_q, q_d;
   logic [CW-1:0]                     cnt_q, cnt_d;
   logic                              edge_c;
   logic [QW-1:0]                     q_out_c;
   logic                              rco_c;
   logic [OW-1:0]                     pipe_in_c;
   logic [OW-1:0]                     pins_o_c;

   assign pins_c = {Pin4, Pin5, Pin9, Pin10, Pin12, Pin13, Pin2, Pin1};
   assign last_c = sync_q[SYNC_STAGES-1];
   assign edge_c = last_c[0] & ~clk_prev_q;

   // CLK sync bits and clk_prev reset high so a held-high Pin1 never looks like a rise
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sync_q     <= {SYNC_STAGES{SYNC_RST}};
         clk_prev_q <= 1'b1;
         q_q        <= '0;
         cnt_q      <= '0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], pins_c};
         clk_prev_q <= last_c[0];
         q_q        <= q_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      q_d   = q_q;
      cnt_d = cnt_q;
      if (edge_c) begin
         if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
         if (!last_c[1] && (Fault_Sel != F_NO_CLR)) begin
            q_d = '0;
         end else if (!last_c[2]) begin
            q_d = (Fault_Sel == F_LD_REV) ? {last_c[4], last_c[5], last_c[6], last_c[7]}
                                          : last_c[7:4];
         end else if (last_c[3] || (Fault_Sel == F_NO_EN)) begin
            q_d = q_q + ((Fault_Sel == F_STEP2) ? QW'(2) : QW'(1));
         end
      end
   end

   // Stuck-at faults are applied at the output-pipeline input
   always_comb begin
      q_out_c = q_q;
      if (Fault_Sel == F_QA_SA0) q_out_c[0] = 1'b0;
      if (Fault_Sel == F_QD_SA1) q_out_c[3] = 1'b1;
      rco_c     = last_c[3] & (q_q == '1) & (Fault_Sel != F_RCO0);
      pipe_in_c = {rco_c, q_out_c};
   end

   if (OUT_DELAY == 0) begin : g_direct
      assign pins_o_c = pipe_in_c;
   end else begin : g_pipe
      logic [OUT_DELAY-1:0][OW-1:0] pipe_q;
      always_ff @(posedge Clk or negedge Reset) begin
         if (!Reset) begin
            pipe_q <= '0;
         end else begin
            pipe_q[0] <= pipe_in_c;
            for (int unsigned i = 1; i < OUT_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end
      assign pins_o_c = pipe_q[OUT_DELAY-1];
   end

   assign {RCO, Pin3, Pin6, Pin8, Pin11} = pins_o_c;
   assign Edge_Cnt = cnt_q;

endmodule

// File: tb/tb_chip_74163_model.sv
// Bench for chip_74163_model (default parameters): event-level model of the
// counter checked every cycle, plus directed literal expectations.
module tb_chip_74163_model;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Pin1 = 1'b1, Pin2 = 1'b1, Pin13 = 1'b1, Pin12 = 1'b0;
   logic       Pin10 = 1'b0, Pin9 = 1'b0, Pin5 = 1'b0, Pin4 = 1'b0;
   logic       Pin11, Pin8, Pin6, Pin3, RCO;
   logic [2:0] Fault_Sel = 3'd0;
   logic [7:0] Edge_Cnt;

   int checks   = 0;
   int failures = 0;

   chip_74163_model #(.SYNC_STAGES(2), .OUT_DELAY(1)) dut (
      .Clk(Clk), .Reset(Reset),
      .Pin1(Pin1), .Pin2(Pin2), .Pin13(Pin13), .Pin12(Pin12),
      .Pin10(Pin10), .Pin9(Pin9), .Pin5(Pin5), .Pin4(Pin4),
      .Pin11(Pin11), .Pin8(Pin8), .Pin6(Pin6), .Pin3(Pin3),
      .RCO(RCO), .Fault_Sel(Fault_Sel), .Edge_Cnt(Edge_Cnt)
   );

   always #5 Clk = ~Clk;

   wire [3:0] q_pins = {Pin3, Pin6, Pin8, Pin11};

   typedef struct packed {
      logic       clk;
      logic       clr;
      logic       ld;
      logic       en;
      logic [3:0] d;
   } smp_t;

   localparam smp_t RST_SMP = 8'h80;

   logic [4:0] exp_pins = '0;
   logic [7:0] exp_cnt  = '0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] next_q(input logic [3:0] q, input smp_t s, input logic [2:0] f);
      logic [3:0] r;
      r = q;
      if (!s.clr && f != 3'd3)   r = 4'd0;
      else if (!s.ld)            r = (f == 3'd6) ? {s.d[0], s.d[1], s.d[2], s.d[3]} : s.d;
      else if (s.en || f == 3'd5) r = 4'((int'(q) + ((f == 3'd4) ? 2 : 1)) % 16);
      return r;
   endfunction

   // Model: a rise seen in the pin samples takes two Clk edges to reach Q, one more to reach the pins
   initial begin
      smp_t       h1, h2, h3, cur;
      logic [3:0] mq, shown;
      logic       rco;
      int         ecnt;
      h1 = RST_SMP; h2 = RST_SMP; h3 = RST_SMP; mq = '0; ecnt = 0;
      forever begin
         @(posedge Clk or negedge Reset);
         if (!Reset) begin
            h1 = RST_SMP; h2 = RST_SMP; h3 = RST_SMP; mq = '0; ecnt = 0;
            exp_pins = '0; exp_cnt = '0;
         end else begin
            cur = {Pin1, Pin2, Pin13, Pin12, Pin4, Pin5, Pin9, Pin10};
            shown = mq;
            if (Fault_Sel == 3'd1) shown[0] = 1'b0;
            if (Fault_Sel == 3'd2) shown[3] = 1'b1;
            rco = h2.en && (mq == 4'd15) && (Fault_Sel != 3'd7);
            exp_pins = {rco, shown};
            if (h2.clk && !h3.clk) begin
               mq = next_q(mq, h2, Fault_Sel);
               if (ecnt < 255) ecnt++;
            end
            exp_cnt = 8'(ecnt);
            h3 = h2; h2 = h1; h1 = cur;
         end
      end
   end

   always @(negedge Clk) begin
      if (Reset === 1'b1) begin
         chk("model_pins", 16'({RCO, Pin3, Pin6, Pin8, Pin11}), 16'(exp_pins));
         chk("model_edge_cnt", 16'(Edge_Cnt), 16'(exp_cnt));
      end
   end

   task automatic drive(input logic clr, input logic ld, input logic en, input logic [3:0] d);
      @(posedge Clk); #1;
      Pin2 = clr; Pin13 = ld; Pin12 = en;
      {Pin4, Pin5, Pin9, Pin10} = d;
   endtask

   task automatic pulse();
      @(posedge Clk); #1 Pin1 = 1'b1;
      @(posedge Clk); #1 Pin1 = 1'b0;
      repeat (5) @(posedge Clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic set_fault(input logic [2:0] f);
      @(posedge Clk); #1 Fault_Sel = f;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with Pin1 held high, then release: no edge may appear
      #23;
      chk("rst_pins", 16'({RCO, q_pins}), 16'h0);
      chk("rst_cnt", 16'(Edge_Cnt), 16'h0);
      @(posedge Clk); #1 Reset = 1'b1;
      idle(10);
      chk("rel_pins", 16'({RCO, q_pins}), 16'h0);
      chk("rel_cnt", 16'(Edge_Cnt), 16'h0);
      @(posedge Clk); #1 Pin1 = 1'b0;
      idle(3);

      // load 1010 with exact three-cycle latency
      drive(1'b1, 1'b0, 1'b0, 4'b1010);
      @(posedge Clk); #1 Pin1 = 1'b1;
      @(posedge Clk); #1 Pin1 = 1'b0;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      chk("lat_early", 16'(q_pins), 16'h0);
      @(posedge Clk); #1;
      chk("lat_load", 16'(q_pins), 16'b1010);
      chk("lat_cnt", 16'(Edge_Cnt), 16'd1);
      idle(3);

      // count through the wrap and RCO
      drive(1'b1, 1'b0, 1'b0, 4'b1101);
      pulse();
      chk("load_1101", 16'(q_pins), 16'b1101);
      drive(1'b1, 1'b1, 1'b1, 4'b0000);
      pulse();
      chk("cnt_1110", 16'({RCO, q_pins}), 16'b0_1110);
      pulse();
      chk("cnt_1111_rco", 16'({RCO, q_pins}), 16'b1_1111);
      pulse();
      chk("cnt_wrap", 16'({RCO, q_pins}), 16'b0_0000);
      chk("cnt_edges5", 16'(Edge_Cnt), 16'd5);
      drive(1'b1, 1'b0, 1'b0, 4'b1111);
      pulse();
      drive(1'b1, 1'b1, 1'b1, 4'b0000);
      idle(4);
      chk("rco_en_hi", 16'({RCO, q_pins}), 16'b1_1111);
      drive(1'b1, 1'b1, 1'b0, 4'b0000);
      idle(4);
      chk("rco_en_lo", 16'({RCO, q_pins}), 16'b0_1111);
      pulse();
      chk("hold_15", 16'({RCO, q_pins}), 16'b0_1111);

      // clear priority and synchronous-only clear
      drive(1'b1, 1'b0, 1'b0, 4'b0111);
      pulse();
      chk("load_7", 16'(q_pins), 16'd7);
      drive(1'b0, 1'b0, 1'b1, 4'b0000);
      idle(5);
      chk("clr_no_edge", 16'(q_pins), 16'd7);
      pulse();
      chk("clr_wins", 16'({RCO, q_pins}), 16'h0);
      chk("clr_edges9", 16'(Edge_Cnt), 16'd9);

      // fault injection
      set_fault(3'd4);
      drive(1'b1, 1'b0, 1'b0, 4'b0000);
      pulse();
      drive(1'b1, 1'b1, 1'b1, 4'b0000);
      pulse(); pulse(); pulse();
      chk("f4_step2", 16'(q_pins), 16'd6);
      set_fault(3'd6);
      drive(1'b1, 1'b0, 1'b0, 4'b0001);
      pulse();
      chk("f6_rev", 16'(q_pins), 16'b1000);
      set_fault(3'd0);
      drive(1'b1, 1'b0, 1'b0, 4'b1111);
      pulse();
      set_fault(3'd1);
      idle(2);
      chk("f1_qa0", 16'(q_pins), 16'b1110);
      set_fault(3'd0);
      drive(1'b1, 1'b1, 1'b1, 4'b0000);
      idle(4);
      set_fault(3'd7);
      idle(2);
      chk("f7_rco0", 16'({RCO, q_pins}), 16'b0_1111);
      drive(1'b0, 1'b1, 1'b0, 4'b0000);
      set_fault(3'd3);
      pulse();
      chk("f3_noclr", 16'(q_pins), 16'd15);
      drive(1'b1, 1'b1, 1'b0, 4'b0000);
      set_fault(3'd5);
      pulse();
      chk("f5_noen", 16'(q_pins), 16'd0);
      set_fault(3'd2);
      idle(2);
      chk("f2_qd1", 16'(q_pins), 16'b1000);
      set_fault(3'd0);
      idle(2);

      // asynchronous reset mid-count
      drive(1'b1, 1'b1, 1'b1, 4'b0000);
      pulse(); pulse();
      @(posedge Clk); #1 Reset = 1'b0;
      #1;
      chk("mid_rst_pins", 16'({RCO, q_pins}), 16'h0);
      chk("mid_rst_cnt", 16'(Edge_Cnt), 16'h0);
      @(posedge Clk); #1 Reset = 1'b1;
      idle(2);
      pulse();
      chk("post_rst_q", 16'(q_pins), 16'd1);
      chk("post_rst_cnt", 16'(Edge_Cnt), 16'd1);

      // Edge_Cnt saturation
      repeat (260) pulse();
      chk("sat_cnt", 16'(Edge_Cnt), 16'd255);
      chk("sat_q", 16'(q_pins), 16'd5);

      @(negedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
